// File: rtl/board_b_d_vram_sched.sv
// VRAM read scheduler for the B-D video board.
// Time-multiplexes the single VRAM read port across NUM_LAYERS playfields:
// tile descriptor words in normal operation, and one row-scroll word per
// layer (the prolog) at each line start. Every issued read carries a tag
// through an RD_LAT-deep pipe so the returning word lands in the right place.
module board_b_d_vram_sched #(
  parameter int          NUM_LAYERS = 3,
  parameter int          WORDS      = 2,
  parameter int          RD_LAT     = 2,
  parameter logic [15:0] RS_BASE    = 16'hf400,
  parameter logic [15:0] RS_STRIDE  = 16'h0400
) (
  input  logic                           CLK_32M,
  input  logic                           reset,
  input  logic                           CE_PIX,
  input  logic                           CLD,
  input  logic [8:0]                     VE,
  input  logic [NUM_LAYERS-1:0]          layer_en,
  input  logic [2*NUM_LAYERS-1:0]        vram_base,
  input  logic [13*NUM_LAYERS-1:0]       tile_index,
  output logic [15:0]                    vram_addr,
  input  logic [15:0]                    vram_data,
  output logic [16*WORDS*NUM_LAYERS-1:0] tile_data,
  output logic [NUM_LAYERS-1:0]          tile_valid,
  output logic [11*NUM_LAYERS-1:0]       row_scroll,
  output logic                           rs_valid,
  output logic                           prolog
);

  localparam int             LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int             WW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int             WSH    = $clog2(WORDS);
  localparam int             TAIL   = RD_LAT - 1;
  localparam logic [LW-1:0]  LAST_L = LW'(NUM_LAYERS - 1);
  localparam logic [WW-1:0]  LAST_W = WW'(WORDS - 1);
  localparam logic [1:0]     LAST_D = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {TILE, PROLOG, PDRAIN} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] cur_l, cur_l_nx;
  logic [WW-1:0] cur_w, cur_w_nx;
  logic [LW-1:0] pcnt, pcnt_nx;
  logic [1:0]    dcnt, dcnt_nx;
  logic [8:0]    ve_q;
  logic [12:0]   idx_q, idx_nx;
  logic          ve_ld, idx_ld;

  // issue request for the coming cycle
  logic          iss, iss_kind;
  logic [LW-1:0] iss_l;
  logic [WW-1:0] iss_w;
  logic [15:0]   addr_nx;

  // slot search result
  logic          hit;
  logic [LW-1:0] sel_l;

  // tag pipe, stage 0 is loaded together with vram_addr
  logic          tag_vld_p  [RD_LAT];
  logic          tag_kind_p [RD_LAT];
  logic [LW-1:0] tag_l_p    [RD_LAT];
  logic [WW-1:0] tag_w_p    [RD_LAT];

  assign prolog = (state == PROLOG) || (state == PDRAIN);

  // Pick the layer for this slot: mid-tile keeps the current layer, at word 0
  // take the first enabled layer from the pointer onwards (wrapping).
  always_comb begin
    logic [LW-1:0] c_l;
    hit   = 1'b0;
    sel_l = cur_l;
    c_l   = cur_l;
    if (cur_w != '0) begin
      hit = 1'b1;
    end else begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (!hit && layer_en[c_l]) begin
          hit   = 1'b1;
          sel_l = c_l;
        end
        c_l = (c_l == LAST_L) ? '0 : c_l + 1'b1;
      end
    end
  end

  // Next-state, slot advance and read issue.
  always_comb begin
    state_nx = state;
    cur_l_nx = cur_l;
    cur_w_nx = cur_w;
    pcnt_nx  = pcnt;
    dcnt_nx  = dcnt;
    ve_ld    = 1'b0;
    idx_ld   = 1'b0;
    idx_nx   = idx_q;
    iss      = 1'b0;
    iss_kind = 1'b0;
    iss_l    = '0;
    iss_w    = '0;
    addr_nx  = '0;
    case (state)
      TILE: begin
        if (CE_PIX && CLD) begin
          // line start: drop any partial tile, restart from slot 0 later
          state_nx = PROLOG;
          ve_ld    = 1'b1;
          pcnt_nx  = '0;
          cur_l_nx = '0;
          cur_w_nx = '0;
        end else if (hit) begin
          iss   = 1'b1;
          iss_l = sel_l;
          iss_w = cur_w;
          if (cur_w == '0) begin
            idx_ld = 1'b1;
            idx_nx = tile_index[13*sel_l +: 13];
          end
          addr_nx = {vram_base[2*sel_l +: 2], 14'd0}
                  + (16'(idx_nx) << (WSH + 1))
                  + (16'(cur_w) << 1);
          if (cur_w == LAST_W) begin
            cur_w_nx = '0;
            cur_l_nx = (sel_l == LAST_L) ? '0 : sel_l + 1'b1;
          end else begin
            cur_w_nx = cur_w + 1'b1;
            cur_l_nx = sel_l;
          end
        end
      end
      PROLOG: begin
        iss      = 1'b1;
        iss_kind = 1'b1;
        iss_l    = pcnt;
        addr_nx  = RS_BASE + 16'(pcnt) * RS_STRIDE + {6'd0, ve_q, 1'b0};
        if (pcnt == LAST_L) begin
          state_nx = PDRAIN;
          dcnt_nx  = '0;
        end else begin
          pcnt_nx = pcnt + 1'b1;
        end
      end
      PDRAIN: begin
        // wait for the last row-scroll word to come back
        if (dcnt == LAST_D) begin
          state_nx = TILE;
          cur_l_nx = '0;
          cur_w_nx = '0;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: state_nx = TILE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) state <= TILE;
    else       state <= state_nx;
  end

  // Slot pointer, prolog/drain counters and the read address register.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      cur_l     <= '0;
      cur_w     <= '0;
      pcnt      <= '0;
      dcnt      <= '0;
      vram_addr <= '0;
    end else begin
      cur_l     <= cur_l_nx;
      cur_w     <= cur_w_nx;
      pcnt      <= pcnt_nx;
      dcnt      <= dcnt_nx;
      vram_addr <= addr_nx;
    end
  end

  // Latched line number and tile index (data only, no reset needed).
  always_ff @(posedge CLK_32M) begin
    if (ve_ld)  ve_q  <= VE;
    if (idx_ld) idx_q <= idx_nx;
  end

  // Tag pipe: stage p0 enters with the address, stage RD_LAT-1 meets the data.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_p[i]  <= 1'b0;
        tag_kind_p[i] <= 1'b0;
        tag_l_p[i]    <= '0;
        tag_w_p[i]    <= '0;
      end
    end else begin
      tag_vld_p[0]  <= iss;
      tag_kind_p[0] <= iss_kind;
      tag_l_p[0]    <= iss_l;
      tag_w_p[0]    <= iss_w;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_p[i]  <= tag_vld_p[i-1];
        tag_kind_p[i] <= tag_kind_p[i-1];
        tag_l_p[i]    <= tag_l_p[i-1];
        tag_w_p[i]    <= tag_w_p[i-1];
      end
    end
  end

  // Write returning data into tile_data / row_scroll and raise completion pulses.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      tile_data  <= '0;
      row_scroll <= '0;
      tile_valid <= '0;
      rs_valid   <= 1'b0;
    end else begin
      tile_valid <= '0;
      rs_valid   <= 1'b0;
      if (tag_vld_p[TAIL]) begin
        if (tag_kind_p[TAIL]) begin
          row_scroll[11*tag_l_p[TAIL] +: 11] <= vram_data[10:0];
          if (tag_l_p[TAIL] == LAST_L) rs_valid <= 1'b1;
        end else begin
          tile_data[16*(WORDS*int'(tag_l_p[TAIL]) + int'(tag_w_p[TAIL])) +: 16] <= vram_data;
          if (tag_w_p[TAIL] == LAST_W) tile_valid[tag_l_p[TAIL]] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_b_d_vram_sched.sv
// Directed bench for board_b_d_vram_sched (3 layers, 2 words, RD_LAT 2).
// VRAM model returns the inverted byte address, delayed by RD_LAT cycles.
module tb_board_b_d_vram_sched;

  localparam int NL = 3;
  localparam int NW = 2;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_pix = 1'b0;
  logic        cld = 1'b0;
  logic [8:0]  ve = '0;
  logic [2:0]  layer_en;
  logic [5:0]  vram_base;
  logic [38:0] tile_index;
  logic [15:0] vram_addr, vram_data;
  logic [95:0] tile_data;
  logic [2:0]  tile_valid;
  logic [32:0] row_scroll;
  logic        rs_valid, prolog;

  logic [15:0] hist0 = '0, hist1 = '0;
  int total = 0, bad = 0;
  int tv1_cnt = 0, rs_cnt = 0;

  board_b_d_vram_sched #(.NUM_LAYERS(NL), .WORDS(NW), .RD_LAT(RL)) dut (
    .CLK_32M    (clk),
    .reset      (rst),
    .CE_PIX     (ce_pix),
    .CLD        (cld),
    .VE         (ve),
    .layer_en   (layer_en),
    .vram_base  (vram_base),
    .tile_index (tile_index),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .tile_data  (tile_data),
    .tile_valid (tile_valid),
    .row_scroll (row_scroll),
    .rs_valid   (rs_valid),
    .prolog     (prolog)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist0 <= vram_addr;
    hist1 <= hist0;
  end
  assign vram_data = (RL == 1) ? ~vram_addr : (RL == 2) ? ~hist0 : ~hist1;

  always @(negedge clk) begin
    if (tile_valid[1]) tv1_cnt <= tv1_cnt + 1;
    if (rs_valid)      rs_cnt  <= rs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [15:0] a, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step;
      if (vram_addr == a) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  // Line start with VE=0x10; optional second CLD while prolog is high.
  task automatic prolog_seq(input bit dbl);
    logic [15:0] ea [7];
    logic        ep [7];
    int rs0;
    ea = '{16'h0000, 16'hF420, 16'hF820, 16'hFC20, 16'h0000, 16'h0000, 16'h0014};
    ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rs0 = rs_cnt;
    ce_pix = 1'b1; cld = 1'b1; ve = 9'h10;
    for (int i = 0; i < 7; i++) begin
      step;
      chk("pro_addr", vram_addr, ea[i]);
      chk("pro_flag", prolog, ep[i]);
      if (i == 5) chk("rs_valid", rs_valid, 1);
      if (i == 0) begin cld = 1'b0; ce_pix = 1'b0; ve = 9'h1FF; end
      if (dbl && i == 1) begin cld = 1'b1; ce_pix = 1'b1; end
      if (dbl && i == 2) begin cld = 1'b0; ce_pix = 1'b0; end
    end
    chk("row_scroll", row_scroll, {11'h3DF, 11'h7DF, 11'h3DF});
    chk("rs_count", rs_cnt - rs0, 1);
  endtask

  initial begin
    logic [15:0] seq [6];
    logic [15:0] seq2 [4];
    logic [15:0] seq3 [5];
    logic [15:0] seq4 [6];
    logic [2:0]  etv;
    int d, t0, r0;
    bit got2;

    seq  = '{16'h0014, 16'h0016, 16'h4018, 16'h401A, 16'h801C, 16'h801E};
    seq2 = '{16'h0014, 16'h0016, 16'h801C, 16'h801E};
    seq3 = '{16'h0016, 16'h4018, 16'h401A, 16'h801C, 16'h801E};
    seq4 = '{16'h0014, 16'h0016, 16'h4018, 16'h401A, 16'h3FFC, 16'h3FFE};

    layer_en   = 3'b111;
    vram_base  = {2'd2, 2'd1, 2'd0};
    tile_index = {13'd7, 13'd6, 13'd5};
    rst = 1'b1;
    repeat (3) step;
    chk("rst_addr", vram_addr, 0);
    chk("rst_tdata", tile_data, 0);
    chk("rst_tvalid", tile_valid, 0);
    chk("rst_rscroll", row_scroll, 0);
    chk("rst_rsvalid", rs_valid, 0);
    chk("rst_prolog", prolog, 0);

    // all layers enabled: round-robin slots and completion pulses
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step;
      chk("tile_addr", vram_addr, seq[(c-1) % 6]);
      d = c - RL;
      etv = (d >= 2 && d % 2 == 0) ? 3'(1 << (((d / 2) - 1) % 3)) : 3'b000;
      chk("tile_valid", tile_valid, etv);
    end
    chk("tile_data", tile_data, 96'h7FE1_7FE3_BFE5_BFE7_FFE9_FFEB);

    // layer 1 disabled: 4-cycle period, no layer-1 pulses
    wait_addr(16'h801E, "wait_801E_a");
    layer_en = 3'b101;
    for (int i = 0; i < 8; i++) begin
      step;
      chk("en101_addr", vram_addr, seq2[i % 4]);
    end
    t0 = tv1_cnt;
    repeat (8) step;
    chk("en101_tv1", tv1_cnt - t0, 0);
    wait_addr(16'h801E, "wait_801E_b");
    layer_en = 3'b111;

    // prolog with a second CLD ignored
    prolog_seq(1'b1);

    // CLD right after layer 1 word 0: partial tile abandoned
    tile_index[25:13] = 13'd9;
    t0 = tv1_cnt;
    got2 = 1'b0;
    for (int i = 0; i < 40 && !got2; i++) begin
      step;
      if (tv1_cnt >= t0 + 2) got2 = 1'b1;
    end
    chk("idx9_done", got2, 1);
    chk("idx9_data", tile_data[63:32], 32'hBFD9_BFDB);
    tile_index[25:13] = 13'd6;
    wait_addr(16'h4018, "wait_4018");
    t0 = tv1_cnt;
    prolog_seq(1'b0);
    chk("abandon_data", tile_data[63:32], 32'hBFD9_BFE7);
    chk("abandon_tv1", tv1_cnt - t0, 0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("restart_addr", vram_addr, seq3[i]);
    end
    repeat (3) step;
    chk("restart_data", tile_data[63:32], 32'hBFE5_BFE7);
    chk("restart_tv1", tv1_cnt - t0, 1);

    // reset during PDRAIN
    r0 = rs_cnt;
    ce_pix = 1'b1; cld = 1'b1; ve = 9'h20;
    step;
    cld = 1'b0; ce_pix = 1'b0;
    repeat (3) step;
    chk("drain_prolog", prolog, 1);
    rst = 1'b1;
    #1;
    chk("arst_addr", vram_addr, 0);
    chk("arst_prolog", prolog, 0);
    chk("arst_tdata", tile_data, 0);
    chk("arst_rscroll", row_scroll, 0);
    chk("arst_tvalid", tile_valid, 0);
    repeat (4) step;
    chk("arst_rscount", rs_cnt - r0, 0);

    // resume from slot 0; layer 2 index wraps mod 2^16
    vram_base[5:4]    = 2'd3;
    tile_index[38:26] = 13'h1FFF;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      chk("wrap_addr", vram_addr, seq4[i]);
    end
    repeat (3) step;
    chk("wrap_data", tile_data[95:64], 32'hC001_C003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
